// File: rtl/iob_modcnt2.sv
// Modulo counter with up/down direction, programmable step, load strobe, runtime modulus
// resync, registered wrap/err pulses; define IOB_MODCNT2_WRAPCNT_EN for the wrap_cnt tally.
module iob_modcnt2 #(
  parameter int DATA_W = 32,
  parameter int STEP_W = 8
`ifdef IOB_MODCNT2_WRAPCNT_EN
  ,
  parameter int WRAP_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  input  logic              ld,
  input  logic [DATA_W-1:0] ld_val,
  input  logic [DATA_W-1:0] mod,
  output logic [DATA_W-1:0] cnt,
  output logic              wrap,
  output logic              err,
  output logic              state_dbg
`ifdef IOB_MODCNT2_WRAPCNT_EN
  ,
  output logic [WRAP_W-1:0] wrap_cnt
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nx;
  logic [DATA_W-1:0] cnt_nx;
  logic              wrap_nx;
  logic              err_nx;
  logic              load;

  // All modulus arithmetic is one bit wider so that mod == 0 can stand for 2^DATA_W.
  logic [DATA_W:0] m_eff;
  logic [DATA_W:0] cnt_ext;
  logic [DATA_W:0] step_ext;
  logic [DATA_W:0] ld_ext;
  logic [DATA_W:0] up_sum;
  logic [DATA_W:0] up_wrapped;
  logic [DATA_W:0] dn_diff;
  logic [DATA_W:0] dn_wrapped;

  assign m_eff      = (mod == '0) ? {1'b1, {DATA_W{1'b0}}} : {1'b0, mod};
  assign cnt_ext    = {1'b0, cnt};
  assign step_ext   = {{(DATA_W + 1 - STEP_W){1'b0}}, step};
  assign ld_ext     = {1'b0, ld_val};
  assign up_sum     = cnt_ext + step_ext;
  assign up_wrapped = up_sum - m_eff;
  assign dn_diff    = cnt_ext - step_ext;
  assign dn_wrapped = cnt_ext + m_eff - step_ext;

  assign state_dbg = (state == RUN);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wrap_nx  = 1'b0;
    err_nx   = 1'b0;
    load     = 1'b0;
    if (ld || (state == IDLE && en)) begin
      // An enable seen in IDLE acts as an implicit load; no count happens that cycle.
      load     = 1'b1;
      state_nx = RUN;
      if (ld_ext < m_eff) begin
        cnt_nx = ld_val;
      end else begin
        cnt_nx = '0;
        err_nx = 1'b1;
      end
    end else if (state == RUN && en) begin
      if (cnt_ext >= m_eff) begin
        // Modulus was lowered below the current value: resync to zero.
        cnt_nx  = '0;
        wrap_nx = 1'b1;
      end else if (step_ext >= m_eff) begin
        err_nx = 1'b1;
      end else if (step != '0) begin
        if (!dir) begin
          if (up_sum >= m_eff) begin
            cnt_nx  = up_wrapped[DATA_W-1:0];
            wrap_nx = 1'b1;
          end else begin
            cnt_nx = up_sum[DATA_W-1:0];
          end
        end else begin
          if (cnt_ext >= step_ext) begin
            cnt_nx = dn_diff[DATA_W-1:0];
          end else begin
            cnt_nx  = dn_wrapped[DATA_W-1:0];
            wrap_nx = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      wrap  <= wrap_nx;
      err   <= err_nx;
    end
  end

`ifdef IOB_MODCNT2_WRAPCNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrap_cnt <= '0;
    end else if (load) begin
      wrap_cnt <= '0;
    end else if (wrap_nx && (wrap_cnt != '1)) begin
      wrap_cnt <= wrap_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_iob_modcnt2.sv
// Directed and randomized bench for iob_modcnt2 against an integer-arithmetic reference model.
module tb_iob_modcnt2;

  localparam int DATA_W   = 8;
  localparam int STEP_W   = 8;
  localparam int WRAP_W   = 2;
  localparam int WRAP_MAX = (1 << WRAP_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              dir;
  logic [STEP_W-1:0] step;
  logic              ld;
  logic [DATA_W-1:0] ld_val;
  logic [DATA_W-1:0] mod;
  logic [DATA_W-1:0] cnt;
  logic              wrap;
  logic              err;
  logic              state_dbg;
`ifdef IOB_MODCNT2_WRAPCNT_EN
  logic [WRAP_W-1:0] wrap_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  int  m_cnt  = 0;
  int  m_wcnt = 0;
  bit  m_run  = 0;
  bit  m_wrap = 0;
  bit  m_err  = 0;
  logic [DATA_W-1:0] exp_q[$];

  iob_modcnt2 #(
    .DATA_W(DATA_W),
    .STEP_W(STEP_W)
`ifdef IOB_MODCNT2_WRAPCNT_EN
    ,
    .WRAP_W(WRAP_W)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .step     (step),
    .ld       (ld),
    .ld_val   (ld_val),
    .mod      (mod),
    .cnt      (cnt),
    .wrap     (wrap),
    .err      (err),
    .state_dbg(state_dbg)
`ifdef IOB_MODCNT2_WRAPCNT_EN
    ,
    .wrap_cnt (wrap_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behavioural model: modular arithmetic on plain integers, evaluated with the inputs
  // present just before the clock edge.
  task automatic model_step();
    int m;
    int s;
    int lv;
    if (!rst) begin
      m_cnt = 0; m_run = 0; m_wrap = 0; m_err = 0; m_wcnt = 0;
    end else begin
      m_wrap = 0;
      m_err  = 0;
      m  = (mod == 0) ? (1 << DATA_W) : int'(mod);
      s  = int'(step);
      lv = int'(ld_val);
      if (ld || (!m_run && en)) begin
        m_run  = 1;
        m_wcnt = 0;
        if (lv < m) m_cnt = lv;
        else begin m_cnt = 0; m_err = 1; end
      end else if (en) begin
        if (m_cnt >= m) begin
          m_cnt = 0; m_wrap = 1;
        end else if (s >= m) begin
          m_err = 1;
        end else if (s != 0) begin
          if (!dir) begin
            m_wrap = (m_cnt + s >= m);
            m_cnt  = (m_cnt + s) % m;
          end else begin
            m_wrap = (m_cnt < s);
            m_cnt  = ((m_cnt - s) % m + m) % m;
          end
        end
      end
      if (m_wrap && m_wcnt < WRAP_MAX) m_wcnt++;
    end
    exp_q.push_back(DATA_W'(m_cnt));
  endtask

  task automatic do_cycle(input string tag);
    logic [DATA_W-1:0] exp_cnt;
    model_step();
    @(posedge clk);
    #1;
    exp_cnt = exp_q.pop_front();
    check({tag, "_cnt"},   32'(cnt),       32'(exp_cnt));
    check({tag, "_wrap"},  32'(wrap),      32'(m_wrap));
    check({tag, "_err"},   32'(err),       32'(m_err));
    check({tag, "_state"}, 32'(state_dbg), 32'(m_run));
`ifdef IOB_MODCNT2_WRAPCNT_EN
    check({tag, "_wcnt"},  32'(wrap_cnt),  32'(m_wcnt));
`endif
  endtask

  task automatic load(input string tag, input int val);
    ld = 1'b1; en = 1'b0; ld_val = DATA_W'(val);
    do_cycle(tag);
    ld = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; dir = 1'b0; step = 8'd1; ld = 1'b0; ld_val = '0; mod = 8'd10;

    // Reset and auto-load
    do_cycle("rst_a");
    do_cycle("rst_b");
    check("plan_rst_cnt", 32'(cnt), 0);
    check("plan_rst_state", 32'(state_dbg), 0);
    rst = 1'b1; ld_val = 8'd5; en = 1'b1;
    do_cycle("autold");
    check("plan_autold", 32'(cnt), 5);
    do_cycle("up_a");
    check("plan_up6", 32'(cnt), 6);
    do_cycle("up_b");
    check("plan_up7", 32'(cnt), 7);

    // Up wrap with step 3
    load("ld8", 8);
    en = 1'b1; step = 8'd3; dir = 1'b0;
    do_cycle("upwrap");
    check("plan_upwrap_cnt", 32'(cnt), 1);
    check("plan_upwrap_wrap", 32'(wrap), 1);
    do_cycle("upnext");
    check("plan_upnext_cnt", 32'(cnt), 4);
    check("plan_upnext_wrap", 32'(wrap), 0);
    en = 1'b0;
    do_cycle("idle_hold");

    // Down wrap
    load("ld1", 1);
    en = 1'b1; dir = 1'b1; step = 8'd3;
    do_cycle("dnwrap");
    check("plan_dnwrap_cnt", 32'(cnt), 8);
    check("plan_dnwrap_wrap", 32'(wrap), 1);
    do_cycle("dnnext");
    check("plan_dnnext_cnt", 32'(cnt), 5);

    // Full range
    mod = 8'd0;
    load("ld255", 255);
    en = 1'b1; dir = 1'b0; step = 8'd1;
    do_cycle("fullwrap");
    check("plan_full_cnt", 32'(cnt), 0);
    check("plan_full_wrap", 32'(wrap), 1);

    // Illegal load, illegal step, resync
    mod = 8'd10;
    load("ld12", 12);
    check("plan_badld_err", 32'(err), 1);
    load("ld4", 4);
    en = 1'b1; step = 8'd10;
    do_cycle("badstep");
    check("plan_badstep_cnt", 32'(cnt), 4);
    check("plan_badstep_err", 32'(err), 1);
    load("ld7", 7);
    mod = 8'd4; en = 1'b1; step = 8'd1;
    do_cycle("resync");
    check("plan_resync_cnt", 32'(cnt), 0);
    check("plan_resync_wrap", 32'(wrap), 1);

    // Priority
    ld = 1'b1; en = 1'b1; ld_val = 8'd3; mod = 8'd10;
    do_cycle("ld_en");
    check("plan_ld_en", 32'(cnt), 3);
    ld_val = 8'd6; rst = 1'b0;
    do_cycle("rst_ld");
    check("plan_rst_ld", 32'(cnt), 0);
    rst = 1'b1; ld = 1'b0;

    // Five wraps to exercise tally saturation
    mod = 8'd2;
    load("ld0", 0);
    en = 1'b1; step = 8'd1; dir = 1'b0;
    for (int i = 0; i < 10; i++) do_cycle("satwrap");
`ifdef IOB_MODCNT2_WRAPCNT_EN
    check("plan_wcnt_sat", 32'(wrap_cnt), 3);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 49) != 0);
      ld   = ($urandom_range(0, 9) == 0);
      en   = ($urandom_range(0, 3) != 0);
      dir  = 1'($urandom_range(0, 1));
      step = STEP_W'($urandom_range(0, 12));
      ld_val = ($urandom_range(0, 7) == 0) ? DATA_W'($urandom_range(0, 255))
                                           : DATA_W'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) mod = DATA_W'($urandom_range(0, 12));
      do_cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
